load_store_unit: RTL

// - Memory-access stage between the datapath and data memory for the multi-cycle RISC-V core.
// - Replaces the control unit's fixed LOAD/LOAD_DONE/LOAD_IDLE timing with a req/done handshake.
// - Takes the ALU effective address, rs2 store data and funct3, then drives byte-masked DMEM accesses.
// - Returns the sign- or zero-extended 64-bit load value for register writeback (mem2reg path).

---
 rtl/load_store_unit.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage between the datapath and data memory.
// Accepts one load/store per req/done handshake. It checks alignment and funct3 legality,
// drives a single byte-masked DMEM access, and returns the sign/zero-extended load value.
//
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   req, we, funct3   request strobe, 1=store/0=load, RV64I size/extension code
//   addr, wr_data     effective byte address, store data (rs2)
//   busy, done, err   not idle, one-cycle completion pulse, error flag valid with done
//   rd_data           extended load result, held until the next successful load
//   mem_en, mem_we    one-cycle DMEM strobe and write enable
//   mem_addr          doubleword index addr[ADDR_W+2:3] (upper address bits ignored)
//   mem_wdata         store data replicated across lanes
//   mem_wmask         byte strobes
//   mem_rdata         DMEM read data, valid MEM_LAT cycles after mem_en
module load_store_unit #(
   parameter int unsigned ADDR_W  = 6,
   parameter int unsigned MEM_LAT = 1   // legal range 1..7
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic              we,
   input  logic [2:0]        funct3,
   input  logic [63:0]       addr,
   input  logic [63:0]       wr_data,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [63:0]       rd_data,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [63:0]       mem_wdata,
   output logic [7:0]        mem_wmask,
   input  logic [63:0]       mem_rdata
);

   typedef enum logic [1:0] {StIdle, StAccess, StWait, StDone} state_e;

   state_e      state_q;
   logic        we_q;
   logic [2:0]  funct3_q;
   logic [2:0]  off_q;
   logic [2:0]  cnt_q;

   logic        misaligned;
   logic        illegal;
   logic        bad_req;
   logic [7:0]  size_mask;
   logic [63:0] wr_lanes;
   logic [63:0] rd_shift;
   logic [63:0] rd_ext;

   // Address bits above the DMEM index are deliberately ignored (wrap-around).
   logic unused_addr;
   assign unused_addr = ^addr[63:ADDR_W+3];

   assign busy = (state_q != StIdle);

   // Request decode on the raw inputs; only meaningful in the cycle req is sampled.
   always_comb begin
      misaligned = 1'b0;
      size_mask  = 8'h00;
      wr_lanes   = wr_data;
      unique case (funct3[1:0])
         2'b00: begin
            size_mask = 8'h01;
            wr_lanes  = {8{wr_data[7:0]}};
         end
         2'b01: begin
            misaligned = addr[0];
            size_mask  = 8'h03;
            wr_lanes   = {4{wr_data[15:0]}};
         end
         2'b10: begin
            misaligned = |addr[1:0];
            size_mask  = 8'h0f;
            wr_lanes   = {2{wr_data[31:0]}};
         end
         2'b11: begin
            misaligned = |addr[2:0];
            size_mask  = 8'hff;
            wr_lanes   = wr_data;
         end
      endcase
      illegal = we ? funct3[2] : (funct3 == 3'b111);
      bad_req = misaligned | illegal;
   end

   // Load alignment and extension from the latched request.
   always_comb begin
      rd_shift = mem_rdata >> {off_q, 3'b000};
      case (funct3_q)
         3'b000:  rd_ext = {{56{rd_shift[7]}}, rd_shift[7:0]};
         3'b001:  rd_ext = {{48{rd_shift[15]}}, rd_shift[15:0]};
         3'b010:  rd_ext = {{32{rd_shift[31]}}, rd_shift[31:0]};
         3'b100:  rd_ext = {56'd0, rd_shift[7:0]};
         3'b101:  rd_ext = {48'd0, rd_shift[15:0]};
         3'b110:  rd_ext = {32'd0, rd_shift[31:0]};
         default: rd_ext = rd_shift;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         we_q      <= 1'b0;
         funct3_q  <= 3'd0;
         off_q     <= 3'd0;
         cnt_q     <= 3'd0;
         done      <= 1'b0;
         err       <= 1'b0;
         rd_data   <= 64'd0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= 64'd0;
         mem_wmask <= 8'h00;
      end else begin
         // Pulsed outputs default low; they are raised for exactly the cycle they apply.
         done   <= 1'b0;
         err    <= 1'b0;
         mem_en <= 1'b0;
         mem_we <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (req) begin
                  we_q     <= we;
                  funct3_q <= funct3;
                  off_q    <= addr[2:0];
                  if (bad_req) begin
                     state_q <= StDone;
                     done    <= 1'b1;
                     err     <= 1'b1;
                  end else begin
                     state_q   <= StAccess;
                     mem_en    <= 1'b1;
                     mem_we    <= we;
                     mem_addr  <= addr[ADDR_W+2:3];
                     mem_wdata <= we ? wr_lanes : 64'd0;
                     mem_wmask <= we ? (size_mask << addr[2:0]) : 8'h00;
                  end
               end
            end
            StAccess: begin
               if (we_q) begin
                  state_q <= StDone;
                  done    <= 1'b1;
               end else begin
                  state_q <= StWait;
                  cnt_q   <= 3'd1;
               end
            end
            StWait: begin
               if (cnt_q == 3'(MEM_LAT)) begin
                  state_q <= StDone;
                  done    <= 1'b1;
                  rd_data <= rd_ext;
               end else begin
                  cnt_q <= cnt_q + 3'd1;
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule
